// File: rtl/tmr32_pwm_seq.sv
// Compare-value sequencer for the 32-bit timer/PWM block.
// Plays a table of (cmpx, cmpy, repeat) entries, advancing on period ends.
module tmr32_pwm_seq #(
  parameter int AW    = 3,
  parameter int RPT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [31:0]      tbl_cmpx,
  input  logic [31:0]      tbl_cmpy,
  input  logic [RPT_W-1:0] tbl_rpt,
  input  logic [AW-1:0]    seq_last,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  input  logic             timeout_flag,
  output logic             tmr_en,
  output logic [31:0]      cmpx,
  output logic [31:0]      cmpy,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_idx
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  logic [31:0]      tx_q [DEPTH];
  logic [31:0]      ty_q [DEPTH];
  logic [RPT_W-1:0] tr_q [DEPTH];

  state_e           state_q;
  logic             tmo_q;
  logic             pend_q;
  logic             loop_q;
  logic [AW-1:0]    last_q;
  logic [AW-1:0]    idx_q;
  logic [RPT_W-1:0] rpt_q;
  logic [31:0]      cmpx_q;
  logic [31:0]      cmpy_q;
  logic             tmr_en_q;
  logic             busy_q;
  logic             done_q;

  logic ev_d;
  logic adv_d;

  // timeout_flag is a level held for a prescaler tick; act on its rise only
  assign ev_d  = timeout_flag & ~tmo_q;
  assign adv_d = ev_d | pend_q;

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tx_q[tbl_addr] <= tbl_cmpx;
      ty_q[tbl_addr] <= tbl_cmpy;
      tr_q[tbl_addr] <= tbl_rpt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmo_q    <= 1'b0;
      pend_q   <= 1'b0;
      loop_q   <= 1'b0;
      last_q   <= '0;
      idx_q    <= '0;
      rpt_q    <= '0;
      cmpx_q   <= '0;
      cmpy_q   <= '0;
      tmr_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tmo_q  <= timeout_flag;
      done_q <= 1'b0;
      if (stop && state_q != S_IDLE) begin
        state_q  <= S_IDLE;
        tmr_en_q <= 1'b0;
        busy_q   <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            pend_q <= 1'b0;
            if (start) begin
              state_q  <= S_LOAD;
              idx_q    <= '0;
              last_q   <= seq_last;
              loop_q   <= loop_en;
              tmr_en_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          S_LOAD: begin
            cmpx_q  <= tx_q[idx_q];
            cmpy_q  <= ty_q[idx_q];
            rpt_q   <= tr_q[idx_q];
            state_q <= S_RUN;
            if (ev_d) pend_q <= 1'b1;
          end
          S_RUN: begin
            pend_q <= 1'b0;
            if (adv_d) begin
              if (rpt_q != '0) begin
                rpt_q <= rpt_q - RPT_W'(1);
              end else if (idx_q != last_q) begin
                idx_q   <= idx_q + AW'(1);
                state_q <= S_LOAD;
              end else if (loop_q) begin
                idx_q   <= '0;
                state_q <= S_LOAD;
              end else begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                tmr_en_q <= 1'b0;
                busy_q   <= 1'b0;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tmr_en  = tmr_en_q;
  assign cmpx    = cmpx_q;
  assign cmpy    = cmpy_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_idx = idx_q;

endmodule

// File: tb/tb_tmr32_pwm_seq.sv
// Self-checking bench for tmr32_pwm_seq.
// Expected entries come from an expanded period list built from the table.
module tb_tmr32_pwm_seq;

  localparam int AW    = 3;
  localparam int RPT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tbl_we = 1'b0;
  logic [AW-1:0]    tbl_addr = '0;
  logic [31:0]      tbl_cmpx = '0;
  logic [31:0]      tbl_cmpy = '0;
  logic [RPT_W-1:0] tbl_rpt = '0;
  logic [AW-1:0]    seq_last = '0;
  logic             loop_en = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             timeout_flag = 1'b0;
  logic             tmr_en;
  logic [31:0]      cmpx;
  logic [31:0]      cmpy;
  logic             busy;
  logic             done;
  logic [AW-1:0]    cur_idx;

  tmr32_pwm_seq #(.AW(AW), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_cmpx(tbl_cmpx), .tbl_cmpy(tbl_cmpy),
    .tbl_rpt(tbl_rpt), .seq_last(seq_last),
    .loop_en(loop_en), .start(start), .stop(stop),
    .timeout_flag(timeout_flag), .tmr_en(tmr_en),
    .cmpx(cmpx), .cmpy(cmpy), .busy(busy),
    .done(done), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int done_cnt = 0;
  int en_low = 0;
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mon_en && tmr_en !== 1'b1) en_low++;
  end

  logic [31:0]      m_x [8];
  logic [31:0]      m_y [8];
  logic [RPT_W-1:0] m_r [8];
  int plist[$];
  bit m_loop;

  // one list element per PWM period, in play order
  function automatic void build(int last);
    plist.delete();
    for (int i = 0; i <= last; i++)
      for (int k = 0; k <= int'(m_r[i]); k++)
        plist.push_back(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(int a, logic [31:0] x,
                             logic [31:0] y, int r);
    tbl_we = 1'b1;
    tbl_addr = AW'(a);
    tbl_cmpx = x;
    tbl_cmpy = y;
    tbl_rpt = RPT_W'(r);
    tick();
    tbl_we = 1'b0;
    m_x[a] = x;
    m_y[a] = y;
    m_r[a] = RPT_W'(r);
  endtask

  task automatic load_scn1();
    write_entry(0, 100, 200, 0);
    write_entry(1, 300, 400, 1);
  endtask

  task automatic start_seq(int last, bit lp);
    seq_last = AW'(last);
    loop_en = lp;
    m_loop = lp;
    build(last);
    start = 1'b1;
    tick();
    start = 1'b0;
    seq_last = AW'($urandom);
    loop_en = 1'($urandom);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pulse(int hold, int gap);
    timeout_flag = 1'b1;
    repeat (hold) tick();
    timeout_flag = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({tmr_en, busy, done, cur_idx, cmpx, cmpy} !== '0) begin
      n_bad++;
      $display("FAIL reset: en=%b busy=%b done=%b idx=%0d cx=%0d cy=%0d, want all 0",
               tmr_en, busy, done, cur_idx, cmpx, cmpy);
    end
  endtask

  task automatic test_oneshot();
    int d0;
    load_scn1();
    d0 = done_cnt;
    start_seq(1, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || tmr_en !== 1'b1) begin
      n_bad++;
      $display("FAIL os_start: busy=%b en=%b, want 1 1", busy, tmr_en);
    end
    tick();
    n_cmp++;
    if (cmpx !== 100 || cmpy !== 200 || cur_idx !== 0) begin
      n_bad++;
      $display("FAIL os_load: cx=%0d cy=%0d idx=%0d, want 100 200 0",
               cmpx, cmpy, cur_idx);
    end
    timeout_flag = 1'b1;
    tick();
    n_cmp++;
    if (cmpx !== 100 || cur_idx !== 1) begin
      n_bad++;
      $display("FAIL os_lat1: cx=%0d idx=%0d, want 100 1", cmpx, cur_idx);
    end
    tick();
    n_cmp++;
    if (cmpx !== 300 || cmpy !== 400) begin
      n_bad++;
      $display("FAIL os_lat2: cx=%0d cy=%0d, want 300 400", cmpx, cmpy);
    end
    tick();
    timeout_flag = 1'b0;
    repeat (3) tick();
    pulse(3, 4);
    n_cmp++;
    if (cur_idx !== 1 || cmpx !== 300 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL os_rpt: idx=%0d cx=%0d busy=%b, want 1 300 1",
               cur_idx, cmpx, busy);
    end
    pulse(3, 4);
    n_cmp++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || tmr_en !== 1'b0
        || cmpx !== 300 || cur_idx !== 1) begin
      n_bad++;
      $display("FAIL os_done: dones=%0d busy=%b en=%b cx=%0d idx=%0d, want 1 0 0 300 1",
               done_cnt - d0, busy, tmr_en, cmpx, cur_idx);
    end
  endtask

  task automatic test_loop();
    int d0, e0, e;
    load_scn1();
    start_seq(1, 1'b1);
    tick();
    d0 = done_cnt;
    e0 = en_low;
    mon_en = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      pulse(3, 4);
      e = plist[n % plist.size()];
      n_cmp++;
      if (cur_idx !== AW'(e) || cmpx !== m_x[e] || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL loop ev%0d: idx=%0d cx=%0d busy=%b, want %0d %0d 1",
                 n, cur_idx, cmpx, busy, e, m_x[e]);
      end
    end
    mon_en = 1'b0;
    n_cmp++;
    if (en_low != e0 || done_cnt != d0) begin
      n_bad++;
      $display("FAIL loop_en: en_low=%0d dones=%0d, want 0 0",
               en_low - e0, done_cnt - d0);
    end
    do_stop();
  endtask

  task automatic test_level();
    for (int i = 0; i < 4; i++) write_entry(i, 10 + i, 20 + i, 0);
    start_seq(3, 1'b1);
    tick();
    pulse(50, 3);
    n_cmp++;
    if (cur_idx !== 1 || cmpx !== 11) begin
      n_bad++;
      $display("FAIL level1: idx=%0d cx=%0d, want 1 11", cur_idx, cmpx);
    end
    pulse(2, 3);
    n_cmp++;
    if (cur_idx !== 2 || cmpx !== 12) begin
      n_bad++;
      $display("FAIL level2: idx=%0d cx=%0d, want 2 12", cur_idx, cmpx);
    end
    do_stop();
  endtask

  task automatic test_stop();
    load_scn1();
    start_seq(1, 1'b0);
    tick();
    pulse(2, 4);
    timeout_flag = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || tmr_en !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_now: busy=%b en=%b done=%b, want 0 0 0",
               busy, tmr_en, done);
    end
    repeat (3) tick();
    timeout_flag = 1'b0;
    tick();
    n_cmp++;
    if (cur_idx !== 1 || cmpx !== 300 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_hold: idx=%0d cx=%0d busy=%b, want 1 300 0",
               cur_idx, cmpx, busy);
    end
    start_seq(1, 1'b0);
    tick();
    n_cmp++;
    if (cur_idx !== 0 || cmpx !== 100 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart: idx=%0d cx=%0d busy=%b, want 0 100 1",
               cur_idx, cmpx, busy);
    end
    do_stop();
  endtask

  task automatic test_simul();
    load_scn1();
    seq_last = 1;
    loop_en = 1'b1;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || tmr_en !== 1'b1) begin
      n_bad++;
      $display("FAIL ss_idle: busy=%b en=%b, want 1 1", busy, tmr_en);
    end
    tick();
    pulse(2, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (cur_idx !== 1 || cmpx !== 300 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ss_busy: idx=%0d cx=%0d busy=%b, want 1 300 1",
               cur_idx, cmpx, busy);
    end
    do_stop();
  endtask

  task automatic test_midreset();
    load_scn1();
    start_seq(1, 1'b1);
    tick();
    pulse(2, 4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({tmr_en, busy, done, cur_idx, cmpx, cmpy} !== '0) begin
      n_bad++;
      $display("FAIL midrst: en=%b busy=%b idx=%0d cx=%0d cy=%0d, want all 0",
               tmr_en, busy, cur_idx, cmpx, cmpy);
    end
    start_seq(1, 1'b0);
    tick();
    n_cmp++;
    if (cmpx !== 100 || cmpy !== 200 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_tbl: cx=%0d cy=%0d busy=%b, want 100 200 1",
               cmpx, cmpy, busy);
    end
    do_stop();
  endtask

  task automatic test_collide();
    logic [31:0] ox, nx, ny;
    for (int i = 0; i < 3; i++) write_entry(i, $urandom, $urandom, 0);
    ox = m_x[2];
    nx = $urandom;
    ny = $urandom;
    start_seq(2, 1'b1);
    tick();
    pulse(2, 4);
    timeout_flag = 1'b1;
    tick();
    tbl_we = 1'b1;
    tbl_addr = 2;
    tbl_cmpx = nx;
    tbl_cmpy = ny;
    tbl_rpt = 0;
    tick();
    tbl_we = 1'b0;
    timeout_flag = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (cur_idx !== 2 || cmpx !== ox) begin
      n_bad++;
      $display("FAIL coll_old: idx=%0d cx=%h, want 2 %h", cur_idx, cmpx, ox);
    end
    m_x[2] = nx;
    m_y[2] = ny;
    repeat (3) pulse(2, 4);
    n_cmp++;
    if (cur_idx !== 2 || cmpx !== nx || cmpy !== ny) begin
      n_bad++;
      $display("FAIL coll_new: idx=%0d cx=%h cy=%h, want 2 %h %h",
               cur_idx, cmpx, cmpy, nx, ny);
    end
    do_stop();
  endtask

  task automatic test_random();
    int last, len, nev, e, d0;
    bit lp, eb;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 8; i++)
        write_entry(i, $urandom, $urandom, $urandom_range(0, 2));
      last = $urandom_range(0, 7);
      lp = 1'($urandom_range(0, 1));
      d0 = done_cnt;
      start_seq(last, lp);
      tick();
      len = plist.size();
      nev = lp ? 2 * len + 1 : len;
      for (int n = 1; n <= nev; n++) begin
        pulse($urandom_range(1, 5), $urandom_range(3, 6));
        eb = m_loop || n < len;
        e = m_loop ? plist[n % len] : plist[(n < len) ? n : len - 1];
        n_cmp++;
        if (cur_idx !== AW'(e) || cmpx !== m_x[e] || cmpy !== m_y[e]
            || busy !== eb || tmr_en !== eb) begin
          n_bad++;
          $display("FAIL rnd%0d ev%0d: idx=%0d cx=%h busy=%b en=%b, want %0d %h %b",
                   it, n, cur_idx, cmpx, busy, tmr_en, e, m_x[e], eb);
        end
      end
      if (lp) do_stop();
      tick();
      n_cmp++;
      if (done_cnt - d0 != (lp ? 0 : 1) || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd%0d end: dones=%0d busy=%b, want %0d 0",
                 it, done_cnt - d0, busy, lp ? 0 : 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop();
    test_level();
    test_stop();
    test_simul();
    test_midreset();
    test_collide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
